// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: receive FSM states, RMII dibit codes, CRC-32 constants,
// error codes and the byte-wide CRC update helper.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_DROP      = 3'd0,
    ST_IDLE      = 3'd1,
    ST_PREAMBLE  = 3'd2,
    ST_DATA      = 3'd3,
    ST_DROP_LONG = 3'd4
  } rx_state_t;

  localparam logic [1:0]  ETH_IDLE_DIBIT     = 2'b00;
  localparam logic [1:0]  ETH_PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  ETH_SFD_DIBIT      = 2'b11;

  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB_20E3;

  localparam logic [1:0]  ETH_ERR_OK    = 2'd0;
  localparam logic [1:0]  ETH_ERR_CRC   = 2'd1;
  localparam logic [1:0]  ETH_ERR_ALIGN = 2'd2;
  localparam logic [1:0]  ETH_ERR_LEN   = 2'd3;

  // Reflected CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = {1'b0, c[31:1]} ^ ETH_CRC_POLY;
      end else begin
        c = {1'b0, c[31:1]};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide single-cycle CRC-32 register (reflected, init all-ones); shared with the TX path.
module eth_crc32 import eth_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_r;

  // CRC register: init has priority over a byte update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_r <= ETH_CRC_INIT;
    end else if (init) begin
      crc_r <= ETH_CRC_INIT;
    end else if (en) begin
      crc_r <= crc32_byte(crc_r, data);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/eth_rmii_rx.sv
// RMII 100 Mb/s receive front end: strips preamble/SFD, assembles bytes, reports length and errors.
// Define ETH_RX_CRC_CHECK_EN to build the FCS residue check (error code 1).
module eth_rmii_rx import eth_pkg::*; #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic        Eth_Clk,
  input  logic        Eth_Rst,
  input  logic        Crs_Dv,
  input  logic [1:0]  Rxd,
  output logic [7:0]  Rx_Byte,
  output logic        Rx_Byte_Vld,
  output logic        Rx_Sof,
  output logic        Rx_Eof,
  output logic [10:0] Rx_Len,
  output logic [1:0]  Rx_Err_Code
);

  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);

  rx_state_t   state_r;
  logic [1:0]  dibit_cnt_r;
  logic [5:0]  byte_sh_r;
  logic [10:0] byte_cnt_r;
  logic [7:0]  byte_s;
  logic        crc_bad_s;
  logic [1:0]  err_code_s;

  // Dibits arrive LSB-first, so the fourth dibit completes bits [7:6].
  assign byte_s = {Rxd, byte_sh_r};

`ifdef ETH_RX_CRC_CHECK_EN
  logic        crc_init_s;
  logic        crc_en_s;
  logic [31:0] crc_s;

  assign crc_init_s = (state_r == ST_PREAMBLE) && Crs_Dv && (Rxd == ETH_SFD_DIBIT);
  assign crc_en_s   = (state_r == ST_DATA) && Crs_Dv && (dibit_cnt_r == 2'd3) &&
                      (byte_cnt_r != MAX_LEN);

  eth_crc32 u_crc (
    .clk  (Eth_Clk),
    .rst  (Eth_Rst),
    .init (crc_init_s),
    .en   (crc_en_s),
    .data (byte_s),
    .crc  (crc_s)
  );

  assign crc_bad_s = (crc_s != ETH_CRC_RESIDUE);
`else
  assign crc_bad_s = 1'b0;
`endif

  // Frame-end status for a normal DATA exit, in priority order length > alignment > CRC.
  always_comb begin
    err_code_s = ETH_ERR_OK;
    if (byte_cnt_r < MIN_LEN) begin
      err_code_s = ETH_ERR_LEN;
    end else if (dibit_cnt_r != 2'd0) begin
      err_code_s = ETH_ERR_ALIGN;
    end else if (crc_bad_s) begin
      err_code_s = ETH_ERR_CRC;
    end else begin
      err_code_s = ETH_ERR_OK;
    end
  end

  // Receive FSM with registered byte strobe, frame markers and status.
  always_ff @(posedge Eth_Clk or posedge Eth_Rst) begin
    if (Eth_Rst) begin
      state_r     <= ST_DROP;
      dibit_cnt_r <= 2'd0;
      byte_sh_r   <= 6'd0;
      byte_cnt_r  <= 11'd0;
      Rx_Byte     <= 8'd0;
      Rx_Byte_Vld <= 1'b0;
      Rx_Sof      <= 1'b0;
      Rx_Eof      <= 1'b0;
      Rx_Len      <= 11'd0;
      Rx_Err_Code <= 2'd0;
    end else begin
      Rx_Byte_Vld <= 1'b0;
      Rx_Sof      <= 1'b0;
      Rx_Eof      <= 1'b0;
      case (state_r)
        ST_DROP: begin
          if (!Crs_Dv) begin
            state_r <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (Crs_Dv) begin
            if (Rxd == ETH_PREAMBLE_DIBIT) begin
              state_r <= ST_PREAMBLE;
            end else if (Rxd != ETH_IDLE_DIBIT) begin
              state_r <= ST_DROP;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!Crs_Dv) begin
            state_r <= ST_IDLE;
          end else if (Rxd == ETH_SFD_DIBIT) begin
            state_r     <= ST_DATA;
            dibit_cnt_r <= 2'd0;
            byte_cnt_r  <= 11'd0;
          end else if (Rxd != ETH_PREAMBLE_DIBIT) begin
            state_r <= ST_DROP;
          end
        end
        ST_DATA: begin
          if (!Crs_Dv) begin
            state_r     <= ST_IDLE;
            Rx_Eof      <= 1'b1;
            Rx_Len      <= byte_cnt_r;
            Rx_Err_Code <= err_code_s;
          end else if (dibit_cnt_r == 2'd3) begin
            dibit_cnt_r <= 2'd0;
            // A byte beyond the maximum is never strobed; the frame is flushed as oversize.
            if (byte_cnt_r == MAX_LEN) begin
              state_r <= ST_DROP_LONG;
            end else begin
              Rx_Byte     <= byte_s;
              Rx_Byte_Vld <= 1'b1;
              Rx_Sof      <= (byte_cnt_r == 11'd0);
              if (byte_cnt_r != 11'h7FF) begin
                byte_cnt_r <= byte_cnt_r + 11'd1;
              end
            end
          end else begin
            byte_sh_r   <= {Rxd, byte_sh_r[5:2]};
            dibit_cnt_r <= dibit_cnt_r + 2'd1;
          end
        end
        ST_DROP_LONG: begin
          if (!Crs_Dv) begin
            state_r     <= ST_IDLE;
            Rx_Eof      <= 1'b1;
            Rx_Len      <= MAX_LEN;
            Rx_Err_Code <= ETH_ERR_LEN;
          end
        end
        default: begin
          state_r <= ST_DROP;
        end
      endcase
    end
  end

endmodule

// File: doc/eth_rmii_rx.md
# eth_rmii_rx

RMII receive front end for the Ethernet datapath. It runs in the `Eth_Clk` domain (50 MHz RMII reference) and consumes the PHY pins `Crs_Dv`/`Rxd[1:0]`. It strips preamble and SFD, assembles dibits into bytes, and emits a byte stream with start and end markers. At frame end it reports frame length and error status, so the downstream receive buffer can commit or discard the frame.

## Interface
Parameters:
- `MIN_FRAME_LEN`, 64 — minimum legal frame length in bytes, counted from DA through FCS.
- `MAX_FRAME_LEN`, 1518 — maximum legal frame length in bytes, counted from DA through FCS.

Ports:
- `Eth_Clk` in 1 — RMII reference clock. The block has one clock.
- `Eth_Rst` in 1 — reset, asynchronous and active-high.
- `Crs_Dv` in 1 — PHY carrier sense / data valid.
- `Rxd` in 2 — PHY receive dibit, LSB-first.
- `Rx_Byte` out 8 — assembled byte.
- `Rx_Byte_Vld` out 1 — one-cycle strobe qualifying `Rx_Byte`.
- `Rx_Sof` out 1 — high together with `Rx_Byte_Vld` on the first byte after the SFD.
- `Rx_Eof` out 1 — one-cycle pulse marking frame end.
- `Rx_Len` out 11 — byte count of the frame; valid with `Rx_Eof`.
- `Rx_Err_Code` out 2 — valid with `Rx_Eof`. Codes: 0 OK, 1 CRC, 2 alignment, 3 length.

## Operation
- All inputs are sampled on the rising edge of `Eth_Clk`. The PHY runs in 100 Mb/s mode, so one dibit is valid per cycle.
- Byte assembly: dibit n lands in bits [2n+1:2n], n = 0..3.
- States:
  - `DROP`: reset state.
    - Leaves to `IDLE` on the first cycle with `Crs_Dv`=0.
    - A reset released mid-frame therefore never emits a partial frame.
  - `IDLE`:
    - `Crs_Dv`=1 with `Rxd`=01 → `PREAMBLE`.
    - `Rxd`=00 (false-carrier idle) stays in `IDLE`.
    - Any other value → `DROP`.
  - `PREAMBLE`:
    - `Rxd`=01 stays in `PREAMBLE`.
    - `Rxd`=11 (SFD tail) → `DATA`, with the dibit counter and byte counter cleared and the CRC set to 0xFFFFFFFF.
    - 00 or 10 → `DROP`.
    - `Crs_Dv`=0 → `IDLE`.
    - No output is produced in this state.
  - `DATA`: assembles bytes.
    - `Crs_Dv`=0 → `IDLE` and schedules `Rx_Eof`.
    - When the byte count reaches `MAX_FRAME_LEN`+1, the length error is latched. Byte strobes stop, and the state moves to `DROP_LONG`.
  - `DROP_LONG`: waits for `Crs_Dv`=0, then → `IDLE` and emits `Rx_Eof` with code 3.
- Byte counter:
  - 11 bits, saturating at 2047.
  - `Rx_Len` reports the count of bytes strobed. For oversize frames it reports `MAX_FRAME_LEN`.
- Error priority, applied at `Rx_Eof`:
  1. Length: count < `MIN_FRAME_LEN`, or oversize.
  2. Alignment: `Crs_Dv` falls with the dibit counter ≠ 0. The partial byte is discarded and not strobed.
  3. CRC.
- CRC-32 check:
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Updated on every strobed byte, including the FCS bytes.
  - The frame is good when the register equals the residue 0xDEBB20E3 at `Crs_Dv` fall.
- Reset values: all outputs are 0, state is `DROP`, CRC is 0xFFFFFFFF, all counters are 0.

## Timing
- `Rx_Byte_Vld` is registered. It asserts one cycle after the cycle in which the 4th dibit is sampled.
- Strobes are at least 4 cycles apart.
- `Rx_Eof` asserts one cycle after the first cycle in which `Crs_Dv` is sampled 0 in `DATA` or `DROP_LONG`.
  - It never coincides with `Rx_Byte_Vld`: the last strobe is at t+1, and `Rx_Eof` is at t+2 or later.
- `Rx_Len` and `Rx_Err_Code` are stable in the `Rx_Eof` cycle and hold until the next `Rx_Eof`.
- There is no backpressure. The consumer must accept every strobe.
- A single-cycle `Crs_Dv` low in `DATA` ends the frame; RMII CRS_DV toggling is not supported.
- `Eth_Rst` asserted mid-frame clears all outputs immediately, with no `Rx_Eof`.

## Configuration
- `ETH_RX_CRC_CHECK_EN` defined: the CRC sub-module is instantiated, and code 1 is reported on residue mismatch.
- Not defined: no CRC logic is built, and code 1 is never produced. The downstream stage checks the FCS.

## Structure
- Shared package `eth_pkg` holds:
  - the state enum;
  - `ETH_PREAMBLE_DIBIT` (2'b01);
  - `ETH_SFD_DIBIT` (2'b11);
  - `ETH_CRC_POLY` (0xEDB88320);
  - `ETH_CRC_RESIDUE` (0xDEBB20E3);
  - the error-code constants.
- Sub-module `eth_crc32`: byte-wide, single-cycle CRC update with `init`/`en`/`data[7:0]` inputs and a `crc[31:0]` output. It is reused by the TX path.

## Test plan
- 64-byte frame (7×0x55 + 0xD5 preamble, payload 0x00..0x3B, correct FCS):
  - exactly 64 strobes, first byte 0x00 with `Rx_Sof`;
  - `Rx_Eof` with `Rx_Len`=64 and code 0.
- Same frame with one payload bit flipped → code 1; with the macro undefined → code 0.
- 60-byte frame with correct FCS → 60 strobes, code 3, `Rx_Len`=60.
- 1600-byte frame → exactly 1518 strobes, then silence, then `Rx_Eof` with code 3 and `Rx_Len`=1518.
- 64-byte frame with `Crs_Dv` dropped after 2 extra dibits → 64 strobes, code 2.
- Corner cases:
  - Reset released mid-frame → no output until the next full preamble.
  - Preamble containing `Rxd`=10 → no output.
